// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID/writeback handshake bundle for the hazard controller
interface pipeline_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_rs1_used;
  logic [4:0] id_rs2;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_rd_wen;
  logic       id_fence;
  logic       flush;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       id_issue;
  logic       id_stall;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
    output id_rd, id_rd_wen, id_fence, flush, wb_valid, wb_rd,
    input  id_issue, id_stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
    input  id_rd, id_rd_wen, id_fence, flush, wb_valid, wb_rd,
    output id_issue, id_stall
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - scoreboard hazard/issue controller for the ID stage
module pipeline_hazard_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = 2,
  parameter int OUT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [NUM_REGS-1:0]  pending_mask,
  output logic [OUT_WIDTH-1:0] outstanding,
  output logic                 state,
  output logic                 wb_underflow
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               st;
  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];

  logic [CNT_WIDTH-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic                 rs1_haz, rs2_haz, waw_sat, hazard;
  logic                 wb_live, inc, dec, underflow_evt;

  assign state   = st;
  assign rs1_cnt = cnt[bus.id_rs1];
  assign rs2_cnt = cnt[bus.id_rs2];
  assign rd_cnt  = cnt[bus.id_rd];
  assign wb_cnt  = cnt[bus.wb_rd];
  assign wb_live = bus.wb_valid && (bus.wb_rd != 5'd0);

  // Write-through regfile: a last pending write retiring this cycle releases the read.
  assign rs1_haz = bus.id_rs1_used && (bus.id_rs1 != 5'd0) && (rs1_cnt != '0) &&
                   !(bus.wb_valid && (bus.wb_rd == bus.id_rs1) && (rs1_cnt == CNT_ONE));
  assign rs2_haz = bus.id_rs2_used && (bus.id_rs2 != 5'd0) && (rs2_cnt != '0) &&
                   !(bus.wb_valid && (bus.wb_rd == bus.id_rs2) && (rs2_cnt == CNT_ONE));
  assign waw_sat = bus.id_rd_wen && (bus.id_rd != 5'd0) && (rd_cnt == CNT_MAX) &&
                   !(bus.wb_valid && (bus.wb_rd == bus.id_rd));
  assign hazard  = rs1_haz || rs2_haz || waw_sat;

  always_comb begin
    bus.id_issue = 1'b0;
    bus.id_stall = 1'b0;
    if (!rst) begin
      if (st == DRAIN) begin
        bus.id_stall = !bus.flush;
      end else if (bus.id_valid && !bus.flush) begin
        if (bus.id_fence) begin
          bus.id_issue = (outstanding == '0);
          bus.id_stall = (outstanding != '0);
        end else begin
          bus.id_issue = !hazard;
          bus.id_stall = hazard;
        end
      end
    end
  end

  assign inc           = bus.id_issue && bus.id_rd_wen && (bus.id_rd != 5'd0) && !bus.id_fence;
  assign dec           = wb_live && (wb_cnt != '0);
  assign underflow_evt = wb_live && (wb_cnt == '0);

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= RUN;
      outstanding  <= '0;
      wb_underflow <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      case (st)
        RUN:   if (bus.id_valid && bus.id_fence && !bus.flush && (outstanding != '0)) st <= DRAIN;
        DRAIN: if (bus.flush || (outstanding == '0)) st <= RUN;
        default: st <= RUN;
      endcase

      outstanding <= outstanding + OUT_WIDTH'(inc) - OUT_WIDTH'(dec);
      if (underflow_evt) wb_underflow <= 1'b1;

      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc && (bus.id_rd == 5'(r)) && !(dec && (bus.wb_rd == 5'(r))))
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec && (bus.wb_rd == 5'(r)) && !(inc && (bus.id_rd == 5'(r))))
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pending_mask;
  logic [6:0]  outstanding;
  logic        state;
  logic        wb_underflow;
  int          n_cmp = 0;
  int          n_err = 0;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl #(.NUM_REGS(32), .CNT_WIDTH(2), .OUT_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .pending_mask(pending_mask),
    .outstanding(outstanding), .state(state), .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_used = 0; bus.id_rs2 = 0; bus.id_rs2_used = 0;
    bus.id_rd = 0; bus.id_rd_wen = 0; bus.id_fence = 0; bus.flush = 0; bus.wb_valid = 0; bus.wb_rd = 0;
  endtask

  task automatic write_to(input logic [4:0] rd);
    idle(); bus.id_valid = 1; bus.id_rd = rd; bus.id_rd_wen = 1;
  endtask

  task automatic wb(input logic [4:0] rd);
    idle(); bus.wb_valid = 1; bus.wb_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1; write_to(5'd5); #1;
    n_cmp++; if (bus.id_issue !== 1'b0) begin n_err++; $display("FAIL rst_issue got %b want 0", bus.id_issue); end
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", bus.id_stall); end
    tick(); tick();
    idle(); rst = 0; tick();
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL rst_mask got %h want 0", pending_mask); end
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL rst_out got %0d want 0", outstanding); end
    n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL rst_state got %b want 0", state); end
    n_cmp++; if (wb_underflow !== 1'b0) begin n_err++; $display("FAIL rst_uf got %b want 0", wb_underflow); end
  endtask

  task automatic test_issue();
    write_to(5'd5); #1;
    n_cmp++; if (bus.id_issue !== 1'b1) begin n_err++; $display("FAIL issue_x5 got %b want 1", bus.id_issue); end
    tick(); idle(); #1;
    n_cmp++; if (pending_mask !== 32'h0000_0020) begin n_err++; $display("FAIL issue_mask got %h want 00000020", pending_mask); end
    n_cmp++; if (outstanding !== 7'd1) begin n_err++; $display("FAIL issue_out got %0d want 1", outstanding); end
  endtask

  task automatic test_raw();
    idle(); bus.id_valid = 1; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1; #1;
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL raw_stall got %b want 1", bus.id_stall); end
    n_cmp++; if (bus.id_issue !== 1'b0) begin n_err++; $display("FAIL raw_noissue got %b want 0", bus.id_issue); end
    tick();
    bus.wb_valid = 1; bus.wb_rd = 5'd5; #1;
    n_cmp++; if (bus.id_issue !== 1'b1) begin n_err++; $display("FAIL raw_wb_issue got %b want 1", bus.id_issue); end
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL raw_wb_stall got %b want 0", bus.id_stall); end
    tick(); idle();
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL raw_mask got %h want 0", pending_mask); end
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL raw_out got %0d want 0", outstanding); end
    // x0 is never tracked: writes and reads of x0 neither count nor stall
    write_to(5'd0); bus.id_rs1_used = 1; #1;
    n_cmp++; if (bus.id_issue !== 1'b1) begin n_err++; $display("FAIL x0_issue got %b want 1", bus.id_issue); end
    tick(); idle();
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL x0_out got %0d want 0", outstanding); end
  endtask

  task automatic test_waw();
    for (int i = 0; i < 3; i++) begin
      write_to(5'd7); #1;
      n_cmp++; if (bus.id_issue !== 1'b1) begin n_err++; $display("FAIL waw_fill%0d got %b want 1", i, bus.id_issue); end
      tick();
    end
    idle();
    n_cmp++; if (outstanding !== 7'd3) begin n_err++; $display("FAIL waw_out3 got %0d want 3", outstanding); end
    write_to(5'd7); #1;
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL waw_sat_stall got %b want 1", bus.id_stall); end
    n_cmp++; if (bus.id_issue !== 1'b0) begin n_err++; $display("FAIL waw_sat_issue got %b want 0", bus.id_issue); end
    tick();
    bus.wb_valid = 1; bus.wb_rd = 5'd7; #1;
    n_cmp++; if (bus.id_issue !== 1'b1) begin n_err++; $display("FAIL waw_wb_issue got %b want 1", bus.id_issue); end
    tick(); idle();
    n_cmp++; if (outstanding !== 7'd3) begin n_err++; $display("FAIL waw_net_out got %0d want 3", outstanding); end
    n_cmp++; if (pending_mask !== 32'h0000_0080) begin n_err++; $display("FAIL waw_mask got %h want 00000080", pending_mask); end
    // count 3 with a writeback still leaves two pending, so the read stays blocked
    bus.id_valid = 1; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1; bus.wb_valid = 1; bus.wb_rd = 5'd7; #1;
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL rs2_multi_stall got %b want 1", bus.id_stall); end
    tick(); wb(5'd7); tick(); tick(); idle();
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL waw_drain_out got %0d want 0", outstanding); end
  endtask

  task automatic test_fence();
    write_to(5'd3); tick(); write_to(5'd4); tick();
    idle(); bus.id_valid = 1; bus.id_fence = 1; bus.id_rd = 5'd3; bus.id_rd_wen = 1; #1;
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL fence_stall got %b want 1", bus.id_stall); end
    tick();
    n_cmp++; if (state !== 1'b1) begin n_err++; $display("FAIL fence_drain got %b want 1", state); end
    bus.wb_valid = 1; bus.wb_rd = 5'd3; #1;
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL drain_stall1 got %b want 1", bus.id_stall); end
    tick(); bus.wb_rd = 5'd4; tick(); bus.wb_valid = 0; #1;
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL drain_out0 got %0d want 0", outstanding); end
    n_cmp++; if (state !== 1'b1) begin n_err++; $display("FAIL drain_still got %b want 1", state); end
    n_cmp++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL drain_stall_last got %b want 1", bus.id_stall); end
    tick();
    n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL fence_run got %b want 0", state); end
    n_cmp++; if (bus.id_issue !== 1'b1) begin n_err++; $display("FAIL fence_issue got %b want 1", bus.id_issue); end
    tick(); idle();
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL fence_noinc got %0d want 0", outstanding); end
  endtask

  task automatic test_flush_drain();
    write_to(5'd6); tick();
    idle(); bus.id_valid = 1; bus.id_fence = 1; tick();
    n_cmp++; if (state !== 1'b1) begin n_err++; $display("FAIL fl_drain got %b want 1", state); end
    bus.flush = 1; #1;
    n_cmp++; if (bus.id_issue !== 1'b0) begin n_err++; $display("FAIL fl_issue got %b want 0", bus.id_issue); end
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got %b want 0", bus.id_stall); end
    tick(); idle();
    n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL fl_run got %b want 0", state); end
    n_cmp++; if (outstanding !== 7'd1) begin n_err++; $display("FAIL fl_out got %0d want 1", outstanding); end
    bus.id_valid = 1; bus.id_rs1 = 5'd6; bus.id_rs1_used = 1; bus.flush = 1; #1;
    n_cmp++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL fl_run_stall got %b want 0", bus.id_stall); end
    tick(); idle();
  endtask

  task automatic test_underflow_reset();
    wb(5'd0); tick(); idle();
    n_cmp++; if (wb_underflow !== 1'b0) begin n_err++; $display("FAIL uf_x0 got %b want 0", wb_underflow); end
    wb(5'd9); tick(); idle();
    n_cmp++; if (wb_underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got %b want 1", wb_underflow); end
    n_cmp++; if (outstanding !== 7'd1) begin n_err++; $display("FAIL uf_out got %0d want 1", outstanding); end
    bus.id_valid = 1; bus.id_fence = 1; tick();
    n_cmp++; if (wb_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got %b want 1", wb_underflow); end
    n_cmp++; if (state !== 1'b1) begin n_err++; $display("FAIL uf_drain got %b want 1", state); end
    rst = 1; tick(); rst = 0; idle(); #1;
    n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL rst2_state got %b want 0", state); end
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL rst2_out got %0d want 0", outstanding); end
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL rst2_mask got %h want 0", pending_mask); end
    n_cmp++; if (wb_underflow !== 1'b0) begin n_err++; $display("FAIL rst2_uf got %b want 0", wb_underflow); end
  endtask

  initial begin
    idle();
    test_reset();
    test_issue();
    test_raw();
    test_waw();
    test_fence();
    test_flush_drain();
    test_underflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
